ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, instruction and immediate width.
- REG_AW, 5, register-select width.
- HALT_DRAIN, 3, cycles to drain after HALT before asserting halt; minimum 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, sole clock, rising edge.
- RST, in, 1, synchronous, active-high reset.
- ihit, in, 1, imemload valid this cycle.
- dhit, in, 1, data access completed this cycle.
- imemload, in, DATA_W, fetched instruction.
- pc_en, out, 1, PC advance enable.
- stall, out, 1, load-use stall (combinational).
- WEN, out, 1, register-file write enable.
- wsel, out, REG_AW, write register.
- rsel1, out, REG_AW, read register 1 (rs).
- rsel2, out, REG_AW, read register 2 (rt).
- ext32, out, DATA_W, extended immediate.
- shamt, out, DATA_W, zero-extended shift amount.
- alu_b_sel, out, 2, ALU B source: 0 = rdat2, 1 = ext32, 2 = shamt.
- rf_wdat_sel, out, 2, write-data source: 0 = ALU, 1 = dmem, 2 = PC+4; 3 is reserved and never driven.
- dREN, out, 1, data read.
- dWEN, out, 1, data write.
- halt, out, 1, sticky halted flag.

Function
REQ-003 Decode SHALL be combinational on imemload; all control outputs except stall and pc_en SHALL be registered in an EX control register, giving 1-cycle latency.
REQ-004 The decode set SHALL be:
- R-type (op 0x00) with funct SLL/SRL: alu_b_sel=2.
- Other R-type: alu_b_sel=0.
- ADDIU 0x09: sign-extended immediate.
- ANDI 0x0C, ORI 0x0D: zero-extended immediate.
- LUI 0x0F: ext32 = {imm, zeros}.
- LW 0x23, SW 0x2B.
- BEQ 0x04, BNE 0x05.
- J 0x02, JAL 0x03.
- HALT 0x3F.
REQ-005 Write select SHALL be:
- wsel = rd for R-type.
- wsel = rt for I-type.
- wsel = 31 for JAL.
- WEN=0 for SW, BEQ, BNE, J, JR, HALT, or when wsel=0.
REQ-006 rf_wdat_sel SHALL be 1 for LW, 2 for JAL, and 0 otherwise; dREN=1 only for LW; dWEN=1 only for SW.
REQ-007 The EX register SHALL load the decoded word only when ihit=1, stall=0, freeze=0 and state=RUN.
- If ihit=0 with no freeze, it SHALL load a bubble: WEN=dREN=dWEN=0.
REQ-008 stall SHALL be 1 when all of the following hold:
- EX holds LW (dREN=1) and EX wsel!=0.
- EX wsel equals the incoming rs, or equals the incoming rt and the incoming instruction reads rt (R-type, SW, BEQ, BNE).
REQ-009 While stall=1: pc_en=0, and a bubble SHALL be loaded.
REQ-010 freeze SHALL be (EX dREN or dWEN) and dhit=0.
- While freeze=1, all registers, including the drain counter, SHALL hold, and pc_en=0.
- freeze SHALL take priority over stall.
REQ-011 pc_en SHALL be ihit and not stall and not freeze and state=RUN.
REQ-012 The halt FSM SHALL have states RUN, DRAIN and HALTED.
- RUN->DRAIN when HALT is accepted into EX; HALT itself enters EX as a bubble, and the counter loads HALT_DRAIN-1.
- In DRAIN: bubbles are loaded, and the counter decrements per unfrozen cycle.
- DRAIN->HALTED when the counter is 0 on an unfrozen cycle.
- HALTED is terminal until RST; halt=1 only in HALTED.
REQ-013 The counter width SHALL be $clog2(HALT_DRAIN+1).
REQ-014 When ihit and dhit both occur during freeze, dhit SHALL release the freeze on the same cycle; the instruction SHALL be accepted only if ihit is still high on a non-freeze cycle.

Reset
REQ-015 On RST=1 at a rising CLK:
- state=RUN, counter=0.
- The EX register SHALL be a bubble: all outputs 0, including halt and stall.
- RST SHALL override any freeze, stall or DRAIN in progress.
REQ-016 The first instruction after RST deasserts SHALL be accepted on the first cycle with ihit=1.

Structure
REQ-017 The alu_b_sel and rf_wdat_sel enums, the opcode/funct constants, and the control-word struct SHALL live in cpu_types_pkg.
REQ-018 Combinational decode SHALL be a sub-module, ctrl_decode; hazard logic, the halt FSM and the EX register SHALL stay in ctrl_pipe.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADDIU r2,r1,-1, ihit=1 -> next cycle: WEN=1, wsel=2, alu_b_sel=1, ext32=0xFFFFFFFF, pc_en=1.
- LW r3,0(r1), then ADDU r4,r3,r5 -> stall=1 and pc_en=0 for 1 cycle, then a bubble; ADDU enters EX one cycle later.
- SW in EX with dhit=0 for 4 cycles -> outputs held and pc_en=0 for 4 cycles; advance on the dhit cycle.
- HALT with HALT_DRAIN=3 -> halt=1 exactly 3 unfrozen cycles after acceptance, and stays 1 for 10+ cycles.
- RST asserted in DRAIN with counter=1 -> next cycle: halt=0, state=RUN, bubble outputs.
- JAL 0x100 -> WEN=1, wsel=31, rf_wdat_sel=2.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared control types for the pipeline control slice: ALU/write-back source enums,
// opcode/funct constants, the EX control word and the halt FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        ALUB_RDAT2 = 2'd0,
        ALUB_EXT32 = 2'd1,
        ALUB_SHAMT = 2'd2
    } alu_b_sel_t;

    // Encoding 3 is left unused on purpose.
    typedef enum logic [1:0] {
        WDAT_ALU  = 2'd0,
        WDAT_DMEM = 2'd1,
        WDAT_PC4  = 2'd2
    } rf_wdat_sel_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef struct packed {
        logic         wen;
        logic         dren;
        logic         dwen;
        alu_b_sel_t   alu_b_sel;
        rf_wdat_sel_t rf_wdat_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, ALUB_RDAT2, WDAT_ALU};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: control word, register selects and immediates.
// Zero latency, no flow control; the caller decides when the result is captured.
module ctrl_decode
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [DATA_W-1:0] imemload,
    output ctrl_t             ctrl,
    output logic              is_halt,
    output logic              reads_rt,
    output logic [REG_AW-1:0] wsel,
    output logic [REG_AW-1:0] rsel1,
    output logic [REG_AW-1:0] rsel2,
    output logic [DATA_W-1:0] ext32,
    output logic [DATA_W-1:0] shamt
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign op    = imemload[31:26];
    assign rs    = imemload[25:21];
    assign rt    = imemload[20:16];
    assign rd    = imemload[15:11];
    assign imm   = imemload[15:0];
    assign funct = imemload[5:0];

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        is_halt  = 1'b0;
        reads_rt = 1'b0;
        wsel     = REG_AW'(rt);
        rsel1    = REG_AW'(rs);
        rsel2    = REG_AW'(rt);
        ext32    = {{(DATA_W-16){imm[15]}}, imm};
        shamt    = DATA_W'(imemload[10:6]);
        case (op)
            OP_RTYPE: begin
                reads_rt       = 1'b1;
                wsel           = REG_AW'(rd);
                ctrl.wen       = (funct != FN_JR);
                ctrl.alu_b_sel = (funct == FN_SLL || funct == FN_SRL) ? ALUB_SHAMT : ALUB_RDAT2;
            end
            OP_ADDIU: begin
                ctrl.wen       = 1'b1;
                ctrl.alu_b_sel = ALUB_EXT32;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.wen       = 1'b1;
                ctrl.alu_b_sel = ALUB_EXT32;
                ext32          = {{(DATA_W-16){1'b0}}, imm};
            end
            OP_LUI: begin
                ctrl.wen       = 1'b1;
                ctrl.alu_b_sel = ALUB_EXT32;
                ext32          = {imm, {(DATA_W-16){1'b0}}};
            end
            OP_LW: begin
                ctrl.wen         = 1'b1;
                ctrl.dren        = 1'b1;
                ctrl.alu_b_sel   = ALUB_EXT32;
                ctrl.rf_wdat_sel = WDAT_DMEM;
            end
            OP_SW: begin
                ctrl.dwen      = 1'b1;
                ctrl.alu_b_sel = ALUB_EXT32;
                reads_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE: reads_rt = 1'b1;
            OP_JAL: begin
                ctrl.wen         = 1'b1;
                wsel             = REG_AW'(31);
                ctrl.rf_wdat_sel = WDAT_PC4;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
        // r0 is hardwired, so a write to it is dropped here rather than in the regfile.
        if (wsel == '0) ctrl.wen = 1'b0;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: decode into a 1-cycle EX control register, load-use stall, memory freeze, halt drain.
// Freeze (pending dmem access) holds everything; stall inserts a bubble; HALT drains then latches halt.
module ctrl_pipe
    import cpu_types_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int HALT_DRAIN = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [DATA_W-1:0] imemload,
    output logic              pc_en,
    output logic              stall,
    output logic              WEN,
    output logic [REG_AW-1:0] wsel,
    output logic [REG_AW-1:0] rsel1,
    output logic [REG_AW-1:0] rsel2,
    output logic [DATA_W-1:0] ext32,
    output logic [DATA_W-1:0] shamt,
    output logic [1:0]        alu_b_sel,
    output logic [1:0]        rf_wdat_sel,
    output logic              dREN,
    output logic              dWEN,
    output logic              halt
);

    localparam int CNT_W = $clog2(HALT_DRAIN + 1);

    ctrl_t             dec_ctrl;
    logic              dec_is_halt;
    logic              dec_reads_rt;
    logic [REG_AW-1:0] dec_wsel, dec_rsel1, dec_rsel2;
    logic [DATA_W-1:0] dec_ext32, dec_shamt;

    ctrl_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
        .imemload (imemload),
        .ctrl     (dec_ctrl),
        .is_halt  (dec_is_halt),
        .reads_rt (dec_reads_rt),
        .wsel     (dec_wsel),
        .rsel1    (dec_rsel1),
        .rsel2    (dec_rsel2),
        .ext32    (dec_ext32),
        .shamt    (dec_shamt)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_wsel_q, ex_wsel_d;
    logic [REG_AW-1:0] ex_rsel1_q, ex_rsel1_d;
    logic [REG_AW-1:0] ex_rsel2_q, ex_rsel2_d;
    logic [DATA_W-1:0] ex_ext32_q, ex_ext32_d;
    logic [DATA_W-1:0] ex_shamt_q, ex_shamt_d;
    logic              freeze;

    always_comb begin
        freeze = (ex_ctrl_q.dren | ex_ctrl_q.dwen) & ~dhit;
        stall  = ex_ctrl_q.dren && (ex_wsel_q != '0) &&
                 ((ex_wsel_q == dec_rsel1) || (dec_reads_rt && ex_wsel_q == dec_rsel2));
        pc_en  = ihit & ~stall & ~freeze & (state_q == ST_RUN);

        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_wsel_d  = ex_wsel_q;
        ex_rsel1_d = ex_rsel1_q;
        ex_rsel2_d = ex_rsel2_q;
        ex_ext32_d = ex_ext32_q;
        ex_shamt_d = ex_shamt_q;

        if (!freeze) begin
            ex_ctrl_d  = CTRL_BUBBLE;
            ex_wsel_d  = '0;
            ex_rsel1_d = '0;
            ex_rsel2_d = '0;
            ex_ext32_d = '0;
            ex_shamt_d = '0;
            case (state_q)
                ST_RUN: begin
                    // pc_en doubles as "instruction accepted into EX this cycle".
                    if (pc_en) begin
                        if (dec_is_halt) begin
                            state_d = ST_DRAIN;
                            cnt_d   = CNT_W'(HALT_DRAIN - 1);
                        end else begin
                            ex_ctrl_d  = dec_ctrl;
                            ex_wsel_d  = dec_wsel;
                            ex_rsel1_d = dec_rsel1;
                            ex_rsel2_d = dec_rsel2;
                            ex_ext32_d = dec_ext32;
                            ex_shamt_d = dec_shamt;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) state_d = ST_HALTED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_HALTED: ;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_wsel_q  <= '0;
            ex_rsel1_q <= '0;
            ex_rsel2_q <= '0;
            ex_ext32_q <= '0;
            ex_shamt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_wsel_q  <= ex_wsel_d;
            ex_rsel1_q <= ex_rsel1_d;
            ex_rsel2_q <= ex_rsel2_d;
            ex_ext32_q <= ex_ext32_d;
            ex_shamt_q <= ex_shamt_d;
        end
    end

    assign WEN         = ex_ctrl_q.wen;
    assign dREN        = ex_ctrl_q.dren;
    assign dWEN        = ex_ctrl_q.dwen;
    assign alu_b_sel   = ex_ctrl_q.alu_b_sel;
    assign rf_wdat_sel = ex_ctrl_q.rf_wdat_sel;
    assign wsel        = ex_wsel_q;
    assign rsel1       = ex_rsel1_q;
    assign rsel2       = ex_rsel2_q;
    assign ext32       = ex_ext32_q;
    assign shamt       = ex_shamt_q;
    assign halt        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode table, load-use stall, memory freeze, halt drain and reset.
module tb_ctrl_pipe;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic        pc_en, stall, WEN, dREN, dWEN, halt;
    logic [4:0]  wsel, rsel1, rsel2;
    logic [31:0] ext32, shamt;
    logic [1:0]  alu_b_sel, rf_wdat_sel;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_pipe #(.DATA_W(32), .REG_AW(5), .HALT_DRAIN(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .imemload    (imemload),
        .pc_en       (pc_en),
        .stall       (stall),
        .WEN         (WEN),
        .wsel        (wsel),
        .rsel1       (rsel1),
        .rsel2       (rsel2),
        .ext32       (ext32),
        .shamt       (shamt),
        .alu_b_sel   (alu_b_sel),
        .rf_wdat_sel (rf_wdat_sel),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .halt        (halt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called 1 time unit after a rising edge; presents one instruction, expects it accepted.
    task automatic dec_vec(input string tag, input logic [31:0] instr, input logic exp_wen,
                           input logic [4:0] exp_wsel, input logic [1:0] exp_b,
                           input logic [1:0] exp_w, input logic exp_dren, input logic exp_dwen,
                           input logic [31:0] exp_ext);
        ihit     = 1'b1;
        dhit     = 1'b1;
        imemload = instr;
        #1;
        chk({tag, ".stall"}, stall, 1'b0);
        chk({tag, ".pc_en"}, pc_en, 1'b1);
        tick();
        chk({tag, ".WEN"}, WEN, exp_wen);
        chk({tag, ".wsel"}, wsel, exp_wsel);
        chk({tag, ".alu_b_sel"}, alu_b_sel, exp_b);
        chk({tag, ".rf_wdat_sel"}, rf_wdat_sel, exp_w);
        chk({tag, ".dREN"}, dREN, exp_dren);
        chk({tag, ".dWEN"}, dWEN, exp_dwen);
        chk({tag, ".ext32"}, ext32, exp_ext);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        ihit     = 1'b0;
        dhit     = 1'b0;
        imemload = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst.WEN", WEN, 1'b0);
        chk("rst.dREN", dREN, 1'b0);
        chk("rst.dWEN", dWEN, 1'b0);
        chk("rst.halt", halt, 1'b0);
        chk("rst.stall", stall, 1'b0);
        chk("rst.pc_en", pc_en, 1'b0);
        chk("rst.wsel", wsel, 5'd0);
        chk("rst.ext32", ext32, 32'h0);
        chk("rst.alu_b_sel", alu_b_sel, 2'd0);
        chk("rst.rf_wdat_sel", rf_wdat_sel, 2'd0);

        // Decode table; first entry is also the first instruction after reset.
        dec_vec("addiu", itype(6'h09, 5'd1, 5'd2, 16'hFFFF), 1, 5'd2, 2'd1, 2'd0, 0, 0, 32'hFFFF_FFFF);
        chk("addiu.rsel1", rsel1, 5'd1);
        dec_vec("andi", itype(6'h0C, 5'd1, 5'd9, 16'h8000), 1, 5'd9, 2'd1, 2'd0, 0, 0, 32'h0000_8000);
        dec_vec("ori", itype(6'h0D, 5'd0, 5'd10, 16'hFFFF), 1, 5'd10, 2'd1, 2'd0, 0, 0, 32'h0000_FFFF);
        dec_vec("lui", itype(6'h0F, 5'd0, 5'd8, 16'h1234), 1, 5'd8, 2'd1, 2'd0, 0, 0, 32'h1234_0000);
        dec_vec("sll", rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h00), 1, 5'd7, 2'd2, 2'd0, 0, 0, 32'h0000_3900);
        chk("sll.shamt", shamt, 32'd4);
        dec_vec("addu", rtype(5'd3, 5'd5, 5'd4, 5'd0, 6'h21), 1, 5'd4, 2'd0, 2'd0, 0, 0, 32'h0000_2021);
        dec_vec("jr", rtype(5'd31, 5'd0, 5'd3, 5'd0, 6'h08), 0, 5'd3, 2'd0, 2'd0, 0, 0, 32'h0000_1808);
        dec_vec("addiu_r0", itype(6'h09, 5'd1, 5'd0, 16'h0005), 0, 5'd0, 2'd1, 2'd0, 0, 0, 32'h0000_0005);
        dec_vec("beq", itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 0, 5'd2, 2'd0, 2'd0, 0, 0, 32'hFFFF_FFFE);
        dec_vec("j", jtype(6'h02, 26'h40), 0, 5'd0, 2'd0, 2'd0, 0, 0, 32'h0000_0040);
        dec_vec("jal", jtype(6'h03, 26'h100), 1, 5'd31, 2'd0, 2'd2, 0, 0, 32'h0000_0100);

        // No instruction available: bubble.
        ihit = 1'b0;
        #1;
        chk("noihit.pc_en", pc_en, 1'b0);
        tick();
        chk("noihit.WEN", WEN, 1'b0);

        // Load-use on rs: one stall cycle, bubble, then ADDU enters.
        dec_vec("lw", itype(6'h23, 5'd1, 5'd3, 16'h0000), 1, 5'd3, 2'd1, 2'd1, 1, 0, 32'h0);
        ihit     = 1'b1;
        dhit     = 1'b1;
        imemload = rtype(5'd3, 5'd5, 5'd4, 5'd0, 6'h21);
        #1;
        chk("lu.stall", stall, 1'b1);
        chk("lu.pc_en", pc_en, 1'b0);
        tick();
        chk("lu.bubble.WEN", WEN, 1'b0);
        chk("lu.bubble.dREN", dREN, 1'b0);
        chk("lu.stall_clear", stall, 1'b0);
        chk("lu.pc_en2", pc_en, 1'b1);
        tick();
        chk("lu.addu.WEN", WEN, 1'b1);
        chk("lu.addu.wsel", wsel, 5'd4);
        chk("lu.addu.rsel1", rsel1, 5'd3);
        chk("lu.addu.rsel2", rsel2, 5'd5);

        // rt match on an I-type that does not read rt: no stall.
        dec_vec("lw2", itype(6'h23, 5'd1, 5'd3, 16'h0000), 1, 5'd3, 2'd1, 2'd1, 1, 0, 32'h0);
        dec_vec("ori_rt", itype(6'h0D, 5'd0, 5'd3, 16'h0001), 1, 5'd3, 2'd1, 2'd0, 0, 0, 32'h1);
        // Load into r0 never stalls.
        dec_vec("lw_r0", itype(6'h23, 5'd1, 5'd0, 16'h0000), 0, 5'd0, 2'd1, 2'd1, 1, 0, 32'h0);
        dec_vec("addu_r0", rtype(5'd0, 5'd0, 5'd4, 5'd0, 6'h21), 1, 5'd4, 2'd0, 2'd0, 0, 0, 32'h2021);

        // Load-use on rt of SW.
        dec_vec("lw3", itype(6'h23, 5'd1, 5'd3, 16'h0000), 1, 5'd3, 2'd1, 2'd1, 1, 0, 32'h0);
        imemload = itype(6'h2B, 5'd1, 5'd3, 16'h0004);
        #1;
        chk("sw_rt.stall", stall, 1'b1);
        tick();
        chk("sw_rt.bubble.WEN", WEN, 1'b0);
        dec_vec("sw", itype(6'h2B, 5'd1, 5'd3, 16'h0004), 0, 5'd3, 2'd1, 2'd0, 0, 1, 32'h4);

        // SW in EX, dmem not done for 4 cycles: everything holds.
        imemload = itype(6'h09, 5'd1, 5'd2, 16'hFFFF);
        ihit     = 1'b1;
        dhit     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz.pc_en", pc_en, 1'b0);
            tick();
            chk("frz.dWEN", dWEN, 1'b1);
            chk("frz.ext32", ext32, 32'h4);
        end
        dhit = 1'b1;
        #1;
        chk("frz.release.pc_en", pc_en, 1'b1);
        tick();
        chk("frz.adv.WEN", WEN, 1'b1);
        chk("frz.adv.wsel", wsel, 5'd2);
        chk("frz.adv.dWEN", dWEN, 1'b0);

        // HALT: halt rises exactly 3 cycles after acceptance and sticks.
        imemload = jtype(6'h3F, 26'h0);
        ihit     = 1'b1;
        dhit     = 1'b0;
        #1;
        chk("halt.accept.pc_en", pc_en, 1'b1);
        tick();
        chk("halt.e0.halt", halt, 1'b0);
        chk("halt.e0.WEN", WEN, 1'b0);
        chk("halt.e0.pc_en", pc_en, 1'b0);
        tick();
        chk("halt.e1.halt", halt, 1'b0);
        tick();
        chk("halt.e2.halt", halt, 1'b0);
        tick();
        chk("halt.e3.halt", halt, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt.sticky", halt, 1'b1);
            chk("halt.pc_en", pc_en, 1'b0);
        end

        // Reset in the middle of DRAIN with the counter at 1.
        do_reset();
        imemload = jtype(6'h3F, 26'h0);
        ihit     = 1'b1;
        dhit     = 1'b1;
        tick();
        tick();
        chk("rstdrain.cnt", dut.cnt_q, 32'd1);
        chk("rstdrain.state_pre", dut.state_q, ST_DRAIN);
        RST = 1'b1;
        tick();
        chk("rstdrain.halt", halt, 1'b0);
        chk("rstdrain.state", dut.state_q, ST_RUN);
        chk("rstdrain.WEN", WEN, 1'b0);
        chk("rstdrain.dREN", dREN, 1'b0);
        chk("rstdrain.cnt0", dut.cnt_q, 32'd0);
        RST = 1'b0;
        dec_vec("post_rst", itype(6'h09, 5'd1, 5'd2, 16'hFFFF), 1, 5'd2, 2'd1, 2'd0, 0, 0, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
